// File: rtl/hazard_ctr.sv
// rtl/hazard_ctr.sv - scoreboard-based hazard, stall and forward-select controller for D stage (optional MDU busy tracking via HAZARD_MDU_EN)
module hazard_ctr #(
    parameter int  STAGES   = 3,
    parameter int  TW       = 2,
    parameter int  MULT_CYC = 5,
    parameter int  DIV_CYC  = 10,
    localparam int SW       = $clog2(STAGES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    D_rs,
    input  logic [4:0]    D_rt,
    input  logic          D_rs_use,
    input  logic          D_rt_use,
    input  logic [TW-1:0] D_Tuse_rs,
    input  logic [TW-1:0] D_Tuse_rt,
    input  logic [4:0]    D_A3,
    input  logic [TW-1:0] D_Tnew,
    input  logic          D_md,
    input  logic          D_md_start,
    input  logic          D_md_div,
    input  logic          flush,
    output logic          stall,
    output logic [SW-1:0] fwd_rs_sel,
    output logic [SW-1:0] fwd_rt_sel,
    output logic          md_busy,
    output logic [4:0]    E_A3
);

    // Scoreboard: index k is the instruction sitting in stage k after D.
    logic [4:0]    a3_q   [1:STAGES];
    logic [4:0]    a3_d   [1:STAGES];
    logic [TW-1:0] tnew_q [1:STAGES];
    logic [TW-1:0] tnew_d [1:STAGES];

    logic          rs_stall;
    logic          rt_stall;
    logic          md_stall;
    logic          accept;

    // An instruction leaves D only when it is neither stalled nor killed.
    assign accept = !stall && !flush;

    // Returns {stall, sel}; scanning from oldest to youngest lets the youngest writer win.
    function automatic logic [SW:0] resolve(input logic [4:0] src,
                                            input logic rd_en,
                                            input logic [TW-1:0] tuse);
        logic [SW:0] r;
        r = '0;
        if (rd_en && (src != 5'd0)) begin
            for (int k = STAGES; k >= 1; k--) begin
                if (a3_q[k] == src) begin
                    if (tnew_q[k] == '0) begin
                        r = {1'b0, SW'(k)};
                    end else if (tnew_q[k] > tuse) begin
                        r = {1'b1, {SW{1'b0}}};
                    end else begin
                        r = '0;
                    end
                end
            end
        end
        return r;
    endfunction

    // Per-source hazard resolution against the current scoreboard.
    always_comb begin
        {rs_stall, fwd_rs_sel} = resolve(D_rs, D_rs_use, D_Tuse_rs);
        {rt_stall, fwd_rt_sel} = resolve(D_rt, D_rt_use, D_Tuse_rt);
    end

    assign stall = rs_stall | rt_stall | md_stall;
    assign E_A3  = a3_q[1];

    // Next scoreboard: stage 1 takes D or a bubble, later stages shift with saturating tnew decrement.
    always_comb begin
        for (int k = 1; k <= STAGES; k++) begin
            a3_d[k]   = '0;
            tnew_d[k] = '0;
        end
        if (accept) begin
            a3_d[1]   = D_A3;
            tnew_d[1] = D_Tnew;
        end
        for (int k = 2; k <= STAGES; k++) begin
            a3_d[k]   = a3_q[k-1];
            tnew_d[k] = (tnew_q[k-1] != '0) ? (tnew_q[k-1] - TW'(1)) : '0;
        end
    end

    // Scoreboard registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= STAGES; k++) begin
                a3_q[k]   <= '0;
                tnew_q[k] <= '0;
            end
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                a3_q[k]   <= a3_d[k];
                tnew_q[k] <= tnew_d[k];
            end
        end
    end

`ifdef HAZARD_MDU_EN
    localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Busy window: load on an accepted start, otherwise count down to idle.
    always_comb begin
        cnt_d = cnt_q;
        if (D_md_start && accept) begin
            cnt_d = D_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // MDU busy counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign md_busy  = (cnt_q != '0);
    assign md_stall = D_md && md_busy;
`else
    logic unused_md;
    assign unused_md = ^{D_md, D_md_start, D_md_div};
    assign md_busy   = 1'b0;
    assign md_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctr.sv
// tb/tb_hazard_ctr.sv - directed self-checking bench for hazard_ctr
module tb_hazard_ctr;

    localparam int STAGES = 3;
    localparam int TW     = 2;
    localparam int SW     = 2;

    logic          clk;
    logic          reset;
    logic [4:0]    D_rs;
    logic [4:0]    D_rt;
    logic          D_rs_use;
    logic          D_rt_use;
    logic [TW-1:0] D_Tuse_rs;
    logic [TW-1:0] D_Tuse_rt;
    logic [4:0]    D_A3;
    logic [TW-1:0] D_Tnew;
    logic          D_md;
    logic          D_md_start;
    logic          D_md_div;
    logic          flush;
    logic          stall;
    logic [SW-1:0] fwd_rs_sel;
    logic [SW-1:0] fwd_rt_sel;
    logic          md_busy;
    logic [4:0]    E_A3;

    int pass_cnt;
    int total_cnt;

    hazard_ctr #(
        .STAGES   (STAGES),
        .TW       (TW),
        .MULT_CYC (5),
        .DIV_CYC  (10)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs       (D_rs),
        .D_rt       (D_rt),
        .D_rs_use   (D_rs_use),
        .D_rt_use   (D_rt_use),
        .D_Tuse_rs  (D_Tuse_rs),
        .D_Tuse_rt  (D_Tuse_rt),
        .D_A3       (D_A3),
        .D_Tnew     (D_Tnew),
        .D_md       (D_md),
        .D_md_start (D_md_start),
        .D_md_div   (D_md_div),
        .flush      (flush),
        .stall      (stall),
        .fwd_rs_sel (fwd_rs_sel),
        .fwd_rt_sel (fwd_rt_sel),
        .md_busy    (md_busy),
        .E_A3       (E_A3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_d();
        D_rs = 0; D_rt = 0; D_rs_use = 0; D_rt_use = 0;
        D_Tuse_rs = 0; D_Tuse_rt = 0; D_A3 = 0; D_Tnew = 0;
        D_md = 0; D_md_start = 0; D_md_div = 0; flush = 0;
        #1;
    endtask

    task automatic drain();
        clear_d();
        for (int i = 0; i < 12; i++) step();
    endtask

    task automatic test_reset();
        clear_d();
        reset = 1'b1;
        #3;
        total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall got %0b want 0", stall); else pass_cnt++;
        total_cnt++; if (fwd_rs_sel !== 2'd0) $display("FAIL reset_fwd_rs got %0d want 0", fwd_rs_sel); else pass_cnt++;
        total_cnt++; if (fwd_rt_sel !== 2'd0) $display("FAIL reset_fwd_rt got %0d want 0", fwd_rt_sel); else pass_cnt++;
        total_cnt++; if (md_busy !== 1'b0) $display("FAIL reset_md_busy got %0b want 0", md_busy); else pass_cnt++;
        total_cnt++; if (E_A3 !== 5'd0) $display("FAIL reset_E_A3 got %0d want 0", E_A3); else pass_cnt++;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_alu_forward();
        drain();
        D_A3 = 5'd8; D_Tnew = 2'd1;
        step();
        clear_d();
        total_cnt++; if (E_A3 !== 5'd8) $display("FAIL alu_E_A3 got %0d want 8", E_A3); else pass_cnt++;
        D_rs = 5'd8; D_rs_use = 1'b1; D_Tuse_rs = 2'd1;
        #1;
        total_cnt++; if (stall !== 1'b0) $display("FAIL alu_stall got %0b want 0", stall); else pass_cnt++;
        total_cnt++; if (fwd_rs_sel !== 2'd0) $display("FAIL alu_sel_s1 got %0d want 0", fwd_rs_sel); else pass_cnt++;
        step();
        D_Tuse_rs = 2'd0;
        #1;
        total_cnt++; if (fwd_rs_sel !== 2'd2) $display("FAIL alu_sel_s2 got %0d want 2", fwd_rs_sel); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL alu_stall_s2 got %0b want 0", stall); else pass_cnt++;
    endtask

    task automatic test_load_use();
        int stall_cycles;
        drain();
        D_A3 = 5'd9; D_Tnew = 2'd2;
        step();
        clear_d();
        D_rt = 5'd9; D_rt_use = 1'b1; D_Tuse_rt = 2'd0; D_A3 = 5'd10; D_Tnew = 2'd1;
        #1;
        stall_cycles = 0;
        for (int i = 0; i < 6 && stall === 1'b1; i++) begin
            total_cnt++; if (fwd_rt_sel !== 2'd0) $display("FAIL lu_sel_while_stall got %0d want 0", fwd_rt_sel); else pass_cnt++;
            stall_cycles++;
            step();
            total_cnt++; if (E_A3 !== 5'd0) $display("FAIL lu_bubble got %0d want 0", E_A3); else pass_cnt++;
        end
        total_cnt++; if (stall_cycles !== 2) $display("FAIL lu_stall_cycles got %0d want 2", stall_cycles); else pass_cnt++;
        total_cnt++; if (fwd_rt_sel !== 2'd3) $display("FAIL lu_sel_release got %0d want 3", fwd_rt_sel); else pass_cnt++;
        step();
        total_cnt++; if (E_A3 !== 5'd10) $display("FAIL lu_enter_E got %0d want 10", E_A3); else pass_cnt++;
    endtask

    task automatic test_youngest();
        drain();
        D_A3 = 5'd5; D_Tnew = 2'd0;
        step();
        step();
        clear_d();
        step();
        D_rs = 5'd5; D_rs_use = 1'b1; D_rt = 5'd5; D_rt_use = 1'b1;
        #1;
        total_cnt++; if (fwd_rs_sel !== 2'd2) $display("FAIL young_rs got %0d want 2", fwd_rs_sel); else pass_cnt++;
        total_cnt++; if (fwd_rt_sel !== 2'd2) $display("FAIL young_rt got %0d want 2", fwd_rt_sel); else pass_cnt++;
        D_rs_use = 1'b0;
        #1;
        total_cnt++; if (fwd_rs_sel !== 2'd0) $display("FAIL young_nouse got %0d want 0", fwd_rs_sel); else pass_cnt++;
        D_rs = 5'd0; D_rs_use = 1'b1; D_rt = 5'd0;
        #1;
        total_cnt++; if (fwd_rs_sel !== 2'd0) $display("FAIL young_r0_sel got %0d want 0", fwd_rs_sel); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL young_r0_stall got %0b want 0", stall); else pass_cnt++;
    endtask

    task automatic test_mdu();
        int busy_cycles;
        int mism;
        drain();
        D_md = 1'b1; D_md_start = 1'b1; D_md_div = 1'b1;
        step();
        clear_d();
        D_md = 1'b1;
        #1;
        busy_cycles = 0;
        mism = 0;
        for (int i = 0; i < 20; i++) begin
            if (md_busy === 1'b1) busy_cycles++;
            if (stall !== md_busy) mism++;
            step();
        end
`ifdef HAZARD_MDU_EN
        total_cnt++; if (busy_cycles !== 10) $display("FAIL md_div_busy got %0d want 10", busy_cycles); else pass_cnt++;
        total_cnt++; if (mism !== 0) $display("FAIL md_stall_track got %0d want 0", mism); else pass_cnt++;
        clear_d();
        D_md = 1'b1; D_md_start = 1'b1;
        step();
        clear_d();
        busy_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            if (md_busy === 1'b1) busy_cycles++;
            step();
        end
        total_cnt++; if (busy_cycles !== 5) $display("FAIL md_mult_busy got %0d want 5", busy_cycles); else pass_cnt++;
`else
        total_cnt++; if (busy_cycles !== 0) $display("FAIL md_off_busy got %0d want 0", busy_cycles); else pass_cnt++;
        total_cnt++; if (mism !== 0) $display("FAIL md_off_stall got %0d want 0", mism); else pass_cnt++;
`endif
        clear_d();
    endtask

    task automatic test_flush();
        drain();
        D_A3 = 5'd9; D_Tnew = 2'd2; D_md = 1'b1; D_md_start = 1'b1; flush = 1'b1;
        step();
        clear_d();
        total_cnt++; if (E_A3 !== 5'd0) $display("FAIL flush_E_A3 got %0d want 0", E_A3); else pass_cnt++;
        total_cnt++; if (md_busy !== 1'b0) $display("FAIL flush_md_busy got %0b want 0", md_busy); else pass_cnt++;
        D_rs = 5'd9; D_rs_use = 1'b1; D_Tuse_rs = 2'd0;
        #1;
        total_cnt++; if (stall !== 1'b0) $display("FAIL flush_stall got %0b want 0", stall); else pass_cnt++;
        step();
        total_cnt++; if (stall !== 1'b0) $display("FAIL flush_stall2 got %0b want 0", stall); else pass_cnt++;
    endtask

    task automatic test_reset_mid_stall();
        drain();
        D_A3 = 5'd9; D_Tnew = 2'd2;
        step();
        clear_d();
        D_rs = 5'd9; D_rs_use = 1'b1; D_Tuse_rs = 2'd0;
        #1;
        total_cnt++; if (stall !== 1'b1) $display("FAIL rst_pre_stall got %0b want 1", stall); else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++; if (stall !== 1'b0) $display("FAIL rst_stall got %0b want 0", stall); else pass_cnt++;
        total_cnt++; if (E_A3 !== 5'd0) $display("FAIL rst_E_A3 got %0d want 0", E_A3); else pass_cnt++;
        total_cnt++; if (fwd_rs_sel !== 2'd0) $display("FAIL rst_fwd got %0d want 0", fwd_rs_sel); else pass_cnt++;
        total_cnt++; if (md_busy !== 1'b0) $display("FAIL rst_md_busy got %0b want 0", md_busy); else pass_cnt++;
        #1;
        reset = 1'b0;
        clear_d();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b0;
        clear_d();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_youngest();
        test_mdu();
        test_flush();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
